// File: rtl/parametric_reservation_station.sv
// Parametrised integer reservation station: collapsing age-ordered queue with CDB wakeup and oldest-ready issue.
// Optional macro RS_CDB_BYPASS_EN: capture a same-cycle CDB broadcast into a dispatching operand.
module parametric_reservation_station #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 6,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_enable,
    input  logic [OPCODE_WIDTH-1:0]    dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]       dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]      dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0]      dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]       dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]       dispatch_rs2_tag,
    input  logic                       dispatch_rs1_data_val,
    input  logic                       dispatch_rs2_data_val,
    input  logic                       cdb_valid,
    input  logic [TAG_WIDTH-1:0]       cdb_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_data,
    input  logic                       issueblk_done,
    output logic                       issueque_full,
    output logic [$clog2(DEPTH+1)-1:0] issueque_count,
    output logic                       issueque_ready,
    output logic [OPCODE_WIDTH-1:0]    issueque_opcode,
    output logic [TAG_WIDTH-1:0]       issueque_rd_tag,
    output logic [DATA_WIDTH-1:0]      issueque_rs1_data,
    output logic [DATA_WIDTH-1:0]      issueque_rs2_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                  ready;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } operand_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [TAG_WIDTH-1:0]    rd_tag;
        operand_t                rs1;
        operand_t                rs2;
    } entry_t;

    entry_t                  slot_q [DEPTH];
    entry_t                  slot_d [DEPTH];
    entry_t                  woke   [DEPTH+1];
    entry_t                  new_e;
    logic [CNT_W-1:0]        count_q, count_d, base;
    logic                    full_q, full_d;
    logic                    ready_q, ready_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [TAG_WIDTH-1:0]    rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic                    do_issue, accept;

    // Next state: wakeup on current slots, collapse over the issued slot, append dispatch,
    // then pre-select the oldest ready entry so all issue outputs come straight from flops.
    always_comb begin
        woke[DEPTH] = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            woke[i] = slot_q[i];
            if (cdb_valid && (CNT_W'(i) < count_q)) begin
                if (!woke[i].rs1.ready && (woke[i].rs1.tag == cdb_tag)) begin
                    woke[i].rs1.ready = 1'b1;
                    woke[i].rs1.data  = cdb_data;
                end
                if (!woke[i].rs2.ready && (woke[i].rs2.tag == cdb_tag)) begin
                    woke[i].rs2.ready = 1'b1;
                    woke[i].rs2.data  = cdb_data;
                end
            end
        end

        do_issue = ready_q && issueblk_done;
        accept   = dispatch_enable && !full_q;
        base     = count_q - CNT_W'(do_issue);

        new_e            = '0;
        new_e.opcode     = dispatch_opcode;
        new_e.rd_tag     = dispatch_rd_tag;
        new_e.rs1.ready  = dispatch_rs1_data_val;
        new_e.rs1.tag    = dispatch_rs1_tag;
        new_e.rs1.data   = dispatch_rs1_data_val ? dispatch_rs1_data : '0;
        new_e.rs2.ready  = dispatch_rs2_data_val;
        new_e.rs2.tag    = dispatch_rs2_tag;
        new_e.rs2.data   = dispatch_rs2_data_val ? dispatch_rs2_data : '0;
`ifdef RS_CDB_BYPASS_EN
        if (!dispatch_rs1_data_val && cdb_valid && (dispatch_rs1_tag == cdb_tag)) begin
            new_e.rs1.ready = 1'b1;
            new_e.rs1.data  = cdb_data;
        end
        if (!dispatch_rs2_data_val && cdb_valid && (dispatch_rs2_tag == cdb_tag)) begin
            new_e.rs2.ready = 1'b1;
            new_e.rs2.data  = cdb_data;
        end
`endif

        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_d[i] = (do_issue && (IDX_W'(i) >= sel_q)) ? woke[i+1] : woke[i];
            if (CNT_W'(i) >= base) begin
                slot_d[i] = '0;
            end
            if (accept && (CNT_W'(i) == base)) begin
                slot_d[i] = new_e;
            end
        end

        count_d = base + CNT_W'(accept);
        full_d  = (count_d == CNT_W'(DEPTH));

        ready_d  = 1'b0;
        sel_d    = '0;
        opcode_d = '0;
        rd_d     = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_d) && slot_d[i].rs1.ready && slot_d[i].rs2.ready) begin
                ready_d  = 1'b1;
                sel_d    = IDX_W'(i);
                opcode_d = slot_d[i].opcode;
                rd_d     = slot_d[i].rd_tag;
                rs1_d    = slot_d[i].rs1.data;
                rs2_d    = slot_d[i].rs2.data;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            count_q  <= '0;
            full_q   <= 1'b0;
            ready_q  <= 1'b0;
            sel_q    <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q  <= count_d;
            full_q   <= full_d;
            ready_q  <= ready_d;
            sel_q    <= sel_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
        end
    end

    assign issueque_full     = full_q;
    assign issueque_count    = count_q;
    assign issueque_ready    = ready_q;
    assign issueque_opcode   = opcode_q;
    assign issueque_rd_tag   = rd_q;
    assign issueque_rs1_data = rs1_q;
    assign issueque_rs2_data = rs2_q;

endmodule

// File: tb/tb_parametric_reservation_station.sv
// Bench for parametric_reservation_station (DEPTH=4); covers both builds of RS_CDB_BYPASS_EN.
module tb_parametric_reservation_station;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_enable;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
    logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
    logic        dispatch_rs1_data_val, dispatch_rs2_data_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issueblk_done;
    logic        issueque_full;
    logic [2:0]  issueque_count;
    logic        issueque_ready;
    logic [3:0]  issueque_opcode;
    logic [5:0]  issueque_rd_tag;
    logic [31:0] issueque_rs1_data, issueque_rs2_data;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    parametric_reservation_station #(
        .DATA_WIDTH(32), .TAG_WIDTH(6), .OPCODE_WIDTH(4), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .dispatch_enable(dispatch_enable), .dispatch_opcode(dispatch_opcode),
        .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_data_val(dispatch_rs1_data_val), .dispatch_rs2_data_val(dispatch_rs2_data_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issueblk_done(issueblk_done),
        .issueque_full(issueque_full), .issueque_count(issueque_count),
        .issueque_ready(issueque_ready), .issueque_opcode(issueque_opcode),
        .issueque_rd_tag(issueque_rd_tag),
        .issueque_rs1_data(issueque_rs1_data), .issueque_rs2_data(issueque_rs2_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: an issue happens at the next rising edge whenever ready and done are both high.
    always @(negedge clk) begin
        if (reset && issueque_ready && issueblk_done) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: rd=%0d rs1=%h with empty scoreboard", issueque_rd_tag, issueque_rs1_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (issueque_opcode !== e.op || issueque_rd_tag !== e.rd ||
                    issueque_rs1_data !== e.a || issueque_rs2_data !== e.b) begin
                    failures++;
                    $display("FAIL issue_payload: got op=%h rd=%0d rs1=%h rs2=%h expected op=%h rd=%0d rs1=%h rs2=%h",
                             issueque_opcode, issueque_rd_tag, issueque_rs1_data, issueque_rs2_data,
                             e.op, e.rd, e.a, e.b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dispatch(input logic [3:0] op, input logic [5:0] rd,
                                  input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                                  input logic [31:0] d2, input logic [5:0] t2, input logic v2);
        dispatch_enable       = 1'b1;
        dispatch_opcode       = op;
        dispatch_rd_tag       = rd;
        dispatch_rs1_data     = d1;
        dispatch_rs1_tag      = t1;
        dispatch_rs1_data_val = v1;
        dispatch_rs2_data     = d2;
        dispatch_rs2_tag      = t2;
        dispatch_rs2_data_val = v2;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [5:0] rd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op = op; e.rd = rd; e.a = a; e.b = b;
        sbq.push_back(e);
    endtask

    task automatic broadcast(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        checks++;
        if (issueque_count !== 3'd0 || issueque_full !== 1'b0 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: count=%0d full=%b ready=%b expected 0 0 0", issueque_count, issueque_full, issueque_ready);
        end
        checks++;
        if ({issueque_opcode, issueque_rd_tag, issueque_rs1_data, issueque_rs2_data} !== 74'd0) begin
            failures++;
            $display("FAIL reset_outputs: op=%h rd=%0d rs1=%h rs2=%h expected all 0",
                     issueque_opcode, issueque_rd_tag, issueque_rs1_data, issueque_rs2_data);
        end
    endtask

    task automatic test_basic_issue();
        issueblk_done = 1'b1;
        drive_dispatch(4'h3, 6'd5, 32'h10, 6'd0, 1'b1, 32'h20, 6'd0, 1'b1);
        push_exp(4'h3, 6'd5, 32'h10, 32'h20);
        tick();
        dispatch_enable = 1'b0;
        checks++;
        if (issueque_ready !== 1'b1 || issueque_count !== 3'd1) begin
            failures++;
            $display("FAIL basic_eligible: ready=%b count=%0d expected 1 1", issueque_ready, issueque_count);
        end
        tick();
        checks++;
        if (issueque_count !== 3'd0 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_removed: count=%0d ready=%b expected 0 0", issueque_count, issueque_ready);
        end
        issueblk_done = 1'b0;
    endtask

    task automatic test_full();
        issueblk_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_dispatch(4'(k), 6'(k + 1), 32'h0, 6'd9, 1'b0, 32'h100 + 32'(k), 6'd0, 1'b1);
            if (k < 4) push_exp(4'(k), 6'(k + 1), 32'h99, 32'h100 + 32'(k));
            if (k == 4) begin
                checks++;
                if (issueque_full !== 1'b1) begin
                    failures++;
                    $display("FAIL full_flag_before_5th: full=%b expected 1", issueque_full);
                end
            end
            tick();
        end
        dispatch_enable = 1'b0;
        checks++;
        if (issueque_count !== 3'd4 || issueque_full !== 1'b1 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: count=%0d full=%b ready=%b expected 4 1 0", issueque_count, issueque_full, issueque_ready);
        end
        broadcast(6'd9, 32'h99);
        checks++;
        if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd1) begin
            failures++;
            $display("FAIL full_wake_all: ready=%b rd=%0d expected 1 1", issueque_ready, issueque_rd_tag);
        end
        // Issue and dispatch together while full: dispatch must be dropped.
        issueblk_done = 1'b1;
        drive_dispatch(4'hF, 6'd63, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
        tick();
        dispatch_enable = 1'b0;
        checks++;
        if (issueque_count !== 3'd3 || issueque_full !== 1'b0) begin
            failures++;
            $display("FAIL full_issue_and_dispatch: count=%0d full=%b expected 3 0", issueque_count, issueque_full);
        end
        tick(); tick(); tick();
        issueblk_done = 1'b0;
        checks++;
        if (issueque_count !== 3'd0 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_drain: count=%0d ready=%b expected 0 0", issueque_count, issueque_ready);
        end
    endtask

    task automatic test_wakeup_order();
        issueblk_done = 1'b0;
        drive_dispatch(4'h1, 6'd10, 32'h0, 6'd7, 1'b0, 32'hA0, 6'd0, 1'b1); tick();
        drive_dispatch(4'h2, 6'd11, 32'h0, 6'd8, 1'b0, 32'hB0, 6'd0, 1'b1); tick();
        drive_dispatch(4'h3, 6'd12, 32'h0, 6'd9, 1'b0, 32'hC0, 6'd0, 1'b1); tick();
        dispatch_enable = 1'b0;
        checks++;
        if (issueque_ready !== 1'b0 || issueque_count !== 3'd3) begin
            failures++;
            $display("FAIL wake_waiting: ready=%b count=%0d expected 0 3", issueque_ready, issueque_count);
        end
        push_exp(4'h2, 6'd11, 32'hABCD, 32'hB0);
        broadcast(6'd8, 32'hABCD);
        checks++;
        if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd11 || issueque_rs1_data !== 32'hABCD) begin
            failures++;
            $display("FAIL wake_middle: ready=%b rd=%0d rs1=%h expected 1 11 0000abcd", issueque_ready, issueque_rd_tag, issueque_rs1_data);
        end
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;
        push_exp(4'h1, 6'd10, 32'h7777, 32'hA0);
        broadcast(6'd7, 32'h7777);
        push_exp(4'h3, 6'd12, 32'h9999, 32'hC0);
        broadcast(6'd9, 32'h9999);
        checks++;
        if (issueque_rd_tag !== 6'd10 || issueque_count !== 3'd2) begin
            failures++;
            $display("FAIL wake_oldest_first: rd=%0d count=%0d expected 10 2", issueque_rd_tag, issueque_count);
        end
        issueblk_done = 1'b1;
        tick(); tick();
        issueblk_done = 1'b0;
        checks++;
        if (issueque_count !== 3'd0) begin
            failures++;
            $display("FAIL wake_drain: count=%0d expected 0", issueque_count);
        end
    endtask

    task automatic test_back_to_back();
        issueblk_done = 1'b0;
        drive_dispatch(4'h5, 6'd20, 32'h2000, 6'd0, 1'b1, 32'h2001, 6'd0, 1'b1); tick();
        drive_dispatch(4'h6, 6'd21, 32'h2100, 6'd0, 1'b1, 32'h2101, 6'd0, 1'b1); tick();
        dispatch_enable = 1'b0;
        push_exp(4'h5, 6'd20, 32'h2000, 32'h2001);
        push_exp(4'h6, 6'd21, 32'h2100, 32'h2101);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (issueque_rd_tag !== 6'd20 || issueque_rs1_data !== 32'h2000 || issueque_count !== 3'd2) begin
                failures++;
                $display("FAIL hold_slot0 cycle %0d: rd=%0d rs1=%h count=%0d expected 20 00002000 2",
                         c, issueque_rd_tag, issueque_rs1_data, issueque_count);
            end
            tick();
        end
        issueblk_done = 1'b1;
        tick(); tick();
        issueblk_done = 1'b0;
        checks++;
        if (issueque_count !== 3'd0 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: count=%0d ready=%b expected 0 0", issueque_count, issueque_ready);
        end
    endtask

    task automatic test_bypass();
        issueblk_done = 1'b0;
        drive_dispatch(4'h7, 6'd22, 32'h0, 6'd12, 1'b0, 32'h66, 6'd0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h55;
        tick();
        dispatch_enable = 1'b0;
        cdb_valid = 1'b0;
`ifdef RS_CDB_BYPASS_EN
        checks++;
        if (issueque_ready !== 1'b1 || issueque_rs1_data !== 32'h55) begin
            failures++;
            $display("FAIL bypass_capture: ready=%b rs1=%h expected 1 00000055", issueque_ready, issueque_rs1_data);
        end
        push_exp(4'h7, 6'd22, 32'h55, 32'h66);
`else
        checks++;
        if (issueque_ready !== 1'b0 || issueque_count !== 3'd1) begin
            failures++;
            $display("FAIL no_bypass_pending: ready=%b count=%0d expected 0 1", issueque_ready, issueque_count);
        end
        push_exp(4'h7, 6'd22, 32'h56, 32'h66);
        broadcast(6'd12, 32'h56);
`endif
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;
        checks++;
        if (issueque_count !== 3'd0) begin
            failures++;
            $display("FAIL bypass_drain: count=%0d expected 0", issueque_count);
        end
    endtask

    task automatic test_reset_mid();
        issueblk_done = 1'b0;
        drive_dispatch(4'h8, 6'd30, 32'h30, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1); tick();
        drive_dispatch(4'h9, 6'd31, 32'h0, 6'd40, 1'b0, 32'h32, 6'd0, 1'b1); tick();
        drive_dispatch(4'hA, 6'd32, 32'h0, 6'd41, 1'b0, 32'h33, 6'd0, 1'b1); tick();
        dispatch_enable = 1'b0;
        checks++;
        if (issueque_count !== 3'd3 || issueque_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: count=%0d ready=%b expected 3 1", issueque_count, issueque_ready);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (issueque_count !== 3'd0 || issueque_ready !== 1'b0 || issueque_full !== 1'b0 ||
            {issueque_opcode, issueque_rd_tag, issueque_rs1_data, issueque_rs2_data} !== 74'd0) begin
            failures++;
            $display("FAIL mid_reset: count=%0d ready=%b rd=%0d rs1=%h expected all 0",
                     issueque_count, issueque_ready, issueque_rd_tag, issueque_rs1_data);
        end
        broadcast(6'd40, 32'h4040);
        broadcast(6'd41, 32'h4141);
        checks++;
        if (issueque_count !== 3'd0 || issueque_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale_cdb: count=%0d ready=%b expected 0 0", issueque_count, issueque_ready);
        end
    endtask

    initial begin
        reset = 1'b0;
        dispatch_enable = 1'b0;
        dispatch_opcode = '0; dispatch_rd_tag = '0;
        dispatch_rs1_data = '0; dispatch_rs2_data = '0;
        dispatch_rs1_tag = '0; dispatch_rs2_tag = '0;
        dispatch_rs1_data_val = 1'b0; dispatch_rs2_data_val = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        issueblk_done = 1'b0;

        test_reset();
        test_basic_issue();
        test_full();
        test_wakeup_order();
        test_back_to_back();
        test_bypass();
        test_reset_mid();

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d expected issues never seen, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parametric_reservation_station.md
# parametric_reservation_station

Parametrised integer reservation station: generalised successor of the fixed integer issue queue. Sits between the dispatch unit and one execution unit. Buffers up to DEPTH dispatched instructions, wakes operands from the CDB, and issues the oldest ready entry whenever the execution unit signals done. Adds configurable depth and widths, strict oldest-first selection, an occupancy output and optional same-cycle CDB bypass at dispatch.

## Interface
- DATA_WIDTH, 32, operand data width
- TAG_WIDTH, 6, rename tag width (rd/rs tags, CDB tag)
- OPCODE_WIDTH, 4, opcode width
- DEPTH, 4, entry count, legal 2..16
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- dispatch_enable  in  1  write one instruction this cycle
- dispatch_opcode  in  OPCODE_WIDTH  opcode
- dispatch_rd_tag  in  TAG_WIDTH  destination tag
- dispatch_rs1_data / dispatch_rs2_data  in  DATA_WIDTH  operand value, meaningful when matching _data_val=1
- dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_WIDTH  producer tag, meaningful when matching _data_val=0
- dispatch_rs1_data_val / dispatch_rs2_data_val  in  1  1 = operand value present
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast tag
- cdb_data  in  DATA_WIDTH  broadcast value
- issueblk_done  in  1  execution unit accepts an instruction this cycle
- issueque_full  out  1  all DEPTH entries occupied
- issueque_count  out  $clog2(DEPTH+1)  occupied entries
- issueque_ready  out  1  at least one entry has both operands ready
- issueque_opcode  out  OPCODE_WIDTH  opcode of selected entry
- issueque_rd_tag  out  TAG_WIDTH  rd tag of selected entry
- issueque_rs1_data / issueque_rs2_data  out  DATA_WIDTH  operands of selected entry

## Operation
- Storage: collapsing age-ordered queue; slot 0 oldest, valid slots contiguous 0..count-1. Per slot: opcode, rd tag, per-operand {ready, tag, data}.
- Dispatch: accepted iff dispatch_enable=1 and issueque_full=0; written into first free slot after any same-cycle removal collapse. Dispatch while full is dropped, no state change.
- Wakeup: each valid slot, each operand with ready=0 and tag==cdb_tag while cdb_valid=1 captures cdb_data, sets ready. Both operands of one slot may wake on the same broadcast.
- Selection: lowest-index slot with both operands ready (oldest-first). issueque_ready = such slot exists. issueque_* outputs driven from that slot; all zero when issueque_ready=0.
- Issue: issueque_ready=1 and issueblk_done=1 at an edge removes the selected slot; younger slots shift down one position, preserving order and any wakeup captured that same edge.
- issueque_full = (count==DEPTH); count +1 on accepted dispatch, -1 on issue, unchanged on both or neither.

## Timing
- Reset (reset=0 at edge): all slots invalid, count 0; issueque_full=0, issueque_ready=0, all issueque_* data/tag/opcode outputs 0. Reset mid-operation discards all entries; CDB and dispatch in that cycle ignored.
- Dispatch-to-issue latency: an entry dispatched with both operands valid is eligible at edge N+1 (outputs valid in the cycle after the dispatch edge).
- CDB wakeup latency: capture at edge N; slot is eligible and outputs show the new data in the cycle following edge N. No combinational CDB-to-issueque_ready path.
- issueque_full, issueque_count, issueque_ready are functions of registered state only; issueque_full=1 stalls dispatch the same cycle.
- Simultaneous issue + dispatch while full: dispatch is dropped (full is registered); count goes DEPTH -> DEPTH-1.
- Simultaneous issue + wakeup of the issued slot's operand: impossible (issued slot already ready); wakeup of other slots applies after shift.

## Configuration
- RS_CDB_BYPASS_EN defined: a dispatch operand with _data_val=0 whose tag equals cdb_tag while cdb_valid=1 in the dispatch cycle is stored as ready with cdb_data.
- Not defined: operand stored not-ready with its tag; the dispatch unit is responsible for forwarding a same-cycle CDB result, otherwise the broadcast is missed.

## Test plan
- Reset then dispatch {op=4'h3, rd=6'd5, rs1=32'h10 valid, rs2=32'h20 valid}, issueblk_done=1 -> next cycle issueque_ready=1, rs1=0x10, rs2=0x20, rd=5; removed next edge, count 1->0.
- DEPTH=4, issueblk_done=0, dispatch 5 instructions with rs1 tag 6'd9 pending -> count=4, issueque_full=1, 5th dropped, issueque_ready=0.
- Three waiting entries on tags 7, 8, 9; broadcast tag 8 data 0xABCD -> only slot 1 ready, issues 0xABCD; broadcast 7 then 9 -> issue order is oldest first.
- Two ready entries plus issueblk_done=0 for 3 cycles -> outputs held on slot 0 stable; then issueblk_done=1 two cycles -> both issue in dispatch order.
- Dispatch rs1 tag 6'd12 pending in same cycle as cdb_valid=1, tag 12, data 0x55 -> with RS_CDB_BYPASS_EN issues 0x55 next cycle; without, entry stays not ready.
- reset=0 with 3 entries, one ready -> next cycle count=0, all outputs 0, subsequent CDB for old tags has no effect.
